fmul_arbiter: RTL and testbench

Shares a single `fmul` instance between `NREQ` independent requesters. Each requester presents operands with a valid/ready handshake. A round-robin arbiter issues at most one multiply per cycle into the multiplier. The multiplier may be combinational or pipelined with fixed latency `LAT`. A tag pipeline routes each `y`/`ovf`/`udf` result back to its requester as a one-cycle pulse. The block sits between the FPU's consumers and the `fmul` datapath, which is instantiated outside this block.

---
 rtl/fmul_arbiter.sv | 168 ++++++++++++++++
 tb/tb_fmul_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_arbiter.sv
// Round-robin sharing of one external fmul between NREQ requesters. A tag pipeline
// matched to the fmul latency steers each result back to its issuer as a one-cycle pulse.
module fmul_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_x1,
  input  logic [32*NREQ-1:0]   req_x2,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      res_valid,
  output logic [31:0]          res_y,
  output logic                 res_ovf,
  output logic                 res_udf,
  output logic [31:0]          fmul_x1,
  output logic [31:0]          fmul_x2,
  input  logic [31:0]          fmul_y,
  input  logic                 fmul_ovf,
  input  logic                 fmul_udf,
  output logic                 idle
);

  localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DEPTH = LAT + 1;

  // One-hot grant to the first eligible index at or above ptr, wrapping.
  function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] elig,
                                              input logic [PW-1:0]   ptr);
    logic [NREQ-1:0] gnt;
    logic [PW-1:0]   idx;
    gnt = '0;
    // Walk from the far end so the candidate nearest ptr is written last.
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (elig[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
      end
    end
    return gnt;
  endfunction

  function automatic logic [PW-1:0] oh2idx(input logic [NREQ-1:0] oh);
    logic [PW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) idx = PW'(i);
    end
    return idx;
  endfunction

  logic [NREQ-1:0] r_busy;
  logic [PW-1:0]   r_ptr;
  logic [DEPTH-1:0] r_tag_vld_p;
  logic [PW-1:0]   r_tag_id_p [DEPTH];
  logic [31:0]     r_fmul_x1;
  logic [31:0]     r_fmul_x2;
  logic [NREQ-1:0] r_res_valid;
  logic [31:0]     r_res_y;
  logic            r_res_ovf;
  logic            r_res_udf;

  logic [NREQ-1:0] w_elig;
  logic [NREQ-1:0] w_grant;
  logic            w_issue;
  logic [PW-1:0]   w_gidx;
  logic [PW-1:0]   w_ptr_nxt;
  logic [31:0]     w_sel_x1;
  logic [31:0]     w_sel_x2;
  logic            w_cap;
  logic [PW-1:0]   w_cap_id;
  logic [NREQ-1:0] w_cap_oh;

  // Issue stage: arbitration and operand select
  assign w_elig    = req_valid & ~r_busy;
  assign w_grant   = rstn ? rr_pick(w_elig, r_ptr) : '0;
  assign w_issue   = |w_grant;
  assign w_gidx    = oh2idx(w_grant);
  assign w_ptr_nxt = (w_gidx == PW'(NREQ - 1)) ? '0 : w_gidx + PW'(1);
  assign req_ready = w_grant;

  always_comb begin
    w_sel_x1 = '0;
    w_sel_x2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_x1 = req_x1[32*i +: 32];
        w_sel_x2 = req_x2[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr     <= '0;
      r_fmul_x1 <= '0;
      r_fmul_x2 <= '0;
    end else if (w_issue) begin
      r_ptr     <= w_ptr_nxt;
      r_fmul_x1 <= w_sel_x1;
      r_fmul_x2 <= w_sel_x2;
    end
  end

  // Tag pipeline: tracks which requester owns the product in each fmul stage
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tag_vld_p <= '0;
    end else begin
      r_tag_vld_p[0] <= w_issue;
      for (int j = 1; j < DEPTH; j++) begin
        r_tag_vld_p[j] <= r_tag_vld_p[j-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    r_tag_id_p[0] <= w_gidx;
    for (int j = 1; j < DEPTH; j++) begin
      r_tag_id_p[j] <= r_tag_id_p[j-1];
    end
  end

  // Capture stage: register the fmul result and route it to its owner
  assign w_cap    = r_tag_vld_p[DEPTH-1];
  assign w_cap_id = r_tag_id_p[DEPTH-1];

  always_comb begin
    w_cap_oh = '0;
    if (w_cap) w_cap_oh[w_cap_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_res_valid <= '0;
      r_res_y     <= '0;
      r_res_ovf   <= 1'b0;
      r_res_udf   <= 1'b0;
    end else begin
      r_res_valid <= w_cap_oh;
      if (w_cap) begin
        r_res_y   <= fmul_y;
        r_res_ovf <= fmul_ovf;
        r_res_udf <= fmul_udf;
      end
    end
  end

  // Clear on capture first, so a same-edge new issue keeps the requester busy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_cap_oh) | w_grant;
    end
  end

  assign fmul_x1   = r_fmul_x1;
  assign fmul_x2   = r_fmul_x2;
  assign res_valid = r_res_valid;
  assign res_y     = r_res_y;
  assign res_ovf   = r_res_ovf;
  assign res_udf   = r_res_udf;
  assign idle      = ~|r_busy & ~|r_tag_vld_p;

endmodule

// File: tb/tb_fmul_arbiter.sv
// Bench for fmul_arbiter: a behavioural fmul with fixed latency, a transaction-level
// reference model (queue of outstanding results) and directed plus random stimulus.
module tb_fmul_arbiter;
  localparam int NREQ = 4;
  localparam int LAT  = 2;
  localparam int PW   = 2;

  logic                clk = 1'b0;
  logic                rstn;
  logic [NREQ-1:0]     req_valid, req_ready, res_valid;
  logic [32*NREQ-1:0]  req_x1, req_x2;
  logic [31:0]         res_y, fmul_x1, fmul_x2, fmul_y;
  logic                res_ovf, res_udf, fmul_ovf, fmul_udf, idle;

  always #5 clk = ~clk;

  fmul_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_x1(req_x1), .req_x2(req_x2), .req_ready(req_ready),
    .res_valid(res_valid), .res_y(res_y), .res_ovf(res_ovf), .res_udf(res_udf),
    .fmul_x1(fmul_x1), .fmul_x2(fmul_x2),
    .fmul_y(fmul_y), .fmul_ovf(fmul_ovf), .fmul_udf(fmul_udf), .idle(idle)
  );

  // Simplified single-precision multiply (truncating, denormals as zero): {ovf, udf, y}
  function automatic logic [33:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] p;
    logic [22:0] man;
    int          e;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {2'b00, s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      man = p[46:24];
      e++;
    end else begin
      man = p[45:23];
    end
    if (e >= 255) return {2'b10, s, 8'hFF, 23'd0};
    if (e <= 0) return {2'b01, s, 31'd0};
    return {2'b00, s, e[7:0], man};
  endfunction

  logic [33:0] fm_pipe [LAT];
  always @(posedge clk) begin
    fm_pipe[0] <= fmul_ref(fmul_x1, fmul_x2);
    for (int j = 1; j < LAT; j++) fm_pipe[j] <= fm_pipe[j-1];
  end
  assign {fmul_ovf, fmul_udf, fmul_y} = fm_pipe[LAT-1];

  typedef struct {
    int            due;
    logic [PW-1:0] id;
    logic [31:0]   y;
    logic          ovf;
    logic          udf;
  } res_t;

  res_t            pend[$];
  int              g_id[$], g_cyc[$], pulse_id[$];
  int              checks = 0, errors = 0, cyc = 0, m_ptr = 0;
  logic [31:0]     m_fx1, m_fx2, m_y;
  logic            m_ovf, m_udf;
  logic [NREQ-1:0] p_vld, p_auto, hs;
  logic [31:0]     p_a [NREQ];
  logic [31:0]     p_b [NREQ];
  logic [31:0]     last_y [NREQ];
  logic            last_ovf [NREQ];
  logic            last_udf [NREQ];
  bit              rand_mode = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    req_valid = p_vld;
    for (int i = 0; i < NREQ; i++) begin
      req_x1[32*i +: 32] = p_a[i];
      req_x2[32*i +: 32] = p_b[i];
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (hs[i]) begin
        if (p_auto[i]) begin
          p_a[i] = $urandom;
          p_b[i] = $urandom;
        end else begin
          p_vld[i] = 1'b0;
        end
      end
      if (rand_mode && !p_vld[i] && $urandom_range(0, 2) == 0) begin
        p_vld[i] = 1'b1;
        p_a[i]   = $urandom;
        p_b[i]   = $urandom;
      end
    end
    hs = '0;
    apply();
  endtask

  task automatic reset_model();
    pend.delete();
    m_ptr = 0;
    m_fx1 = '0; m_fx2 = '0; m_y = '0;
    m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  // Per-cycle comparison of every output against the transaction-level model.
  task automatic model_cycle();
    logic [NREQ-1:0] exp_rv, busy, elig, exp_rdy;
    logic [33:0]     r;
    logic [PW-1:0]   idx;
    int              g;
    cyc++;
    exp_rv = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      exp_rv[pend[0].id] = 1'b1;
      m_y   = pend[0].y;
      m_ovf = pend[0].ovf;
      m_udf = pend[0].udf;
      void'(pend.pop_front());
    end
    chk("res_valid", 32'(res_valid), 32'(exp_rv));
    chk("res_y", res_y, m_y);
    chk("res_ovf", 32'(res_ovf), 32'(m_ovf));
    chk("res_udf", 32'(res_udf), 32'(m_udf));
    chk("fmul_x1", fmul_x1, m_fx1);
    chk("fmul_x2", fmul_x2, m_fx2);
    for (int i = 0; i < NREQ; i++) begin
      if (res_valid[i]) begin
        last_y[i]   = res_y;
        last_ovf[i] = res_ovf;
        last_udf[i] = res_udf;
        pulse_id.push_back(i);
      end
    end
    busy = '0;
    foreach (pend[k]) busy[pend[k].id] = 1'b1;
    chk("idle", 32'(idle), 32'(pend.size() == 0));
    elig = p_vld & ~busy;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((m_ptr + k) % NREQ);
      if (g < 0 && elig[idx]) g = int'(idx);
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[PW'(g)] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (g >= 0) begin
      r = fmul_ref(p_a[g], p_b[g]);
      pend.push_back('{due: cyc + LAT + 2, id: PW'(g), y: r[31:0], ovf: r[33], udf: r[32]});
      m_fx1 = p_a[g];
      m_fx2 = p_b[g];
      m_ptr = (g + 1) % NREQ;
      g_id.push_back(g);
      g_cyc.push_back(cyc);
      hs[PW'(g)] = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    model_cycle();
  endtask

  task automatic do_reset(input logic [NREQ-1:0] vld_during);
    @(posedge clk);
    #1;
    rstn   = 1'b0;
    p_vld  = vld_during;
    p_auto = '0;
    hs     = '0;
    apply();
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_y", res_y, 32'd0);
    chk("rst_flags", {30'd0, res_ovf, res_udf}, 32'd0);
    chk("rst_fmul_x", fmul_x1 | fmul_x2, 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    p_vld = '0;
    apply();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    reset_model();
  endtask

  task automatic clear_logs();
    g_id.delete();
    g_cyc.delete();
    pulse_id.delete();
  endtask

  initial begin
    rstn = 1'b0;
    p_vld = '0; p_auto = '0; hs = '0;
    for (int i = 0; i < NREQ; i++) begin
      p_a[i] = '0; p_b[i] = '0;
      last_y[i] = '0; last_ovf[i] = 1'b0; last_udf[i] = 1'b0;
    end
    apply();
    reset_model();
    do_reset('1);

    // Single request from requester 0
    p_vld[0] = 1'b1; p_a[0] = 32'h3F800000; p_b[0] = 32'h40000000;
    step();
    step();
    chk("single_fmul_x1", fmul_x1, 32'h3F800000);
    repeat (LAT + 1) step();
    chk("single_res_valid", 32'(res_valid), 32'b0001);
    chk("single_res_y", res_y, 32'h40000000);
    chk("single_flags", {30'd0, res_ovf, res_udf}, 32'd0);
    chk("single_idle", 32'(idle), 32'd1);

    // Full contention straight after reset
    do_reset('0);
    clear_logs();
    for (int i = 0; i < NREQ; i++) begin
      p_vld[i] = 1'b1;
      p_a[i]   = 32'h3F800000 + (i << 23);
      p_b[i]   = 32'h40400000;
    end
    repeat (NREQ + LAT + 3) step();
    for (int k = 0; k < NREQ; k++) begin
      chk("cont_grant_order", 32'((k < g_id.size()) ? g_id[k] : -1), 32'(k));
      chk("cont_grant_cycle", 32'((k < g_cyc.size()) ? g_cyc[k] - g_cyc[0] : -1), 32'(k));
      chk("cont_pulse_order", 32'((k < pulse_id.size()) ? pulse_id[k] : -1), 32'(k));
    end
    chk("cont_y0", last_y[0], 32'h40400000);
    chk("cont_y1", last_y[1], 32'h40C00000);
    chk("cont_y2", last_y[2], 32'h41400000);
    chk("cont_y3", last_y[3], 32'h41C00000);

    // Fairness: after a grant to 2, requesters 0 and 3 arrive together
    do_reset('0);
    clear_logs();
    p_vld[2] = 1'b1; p_a[2] = 32'h40000000; p_b[2] = 32'h40000000;
    step();
    p_vld[0] = 1'b1; p_a[0] = 32'h3FC00000; p_b[0] = 32'h40000000;
    p_vld[3] = 1'b1; p_a[3] = 32'h40800000; p_b[3] = 32'h3F000000;
    repeat (LAT + 5) step();
    chk("fair_count", 32'(g_id.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      chk("fair_order", 32'((k < g_id.size()) ? g_id[k] : -1), (k == 0) ? 32'd2 : (k == 1) ? 32'd3 : 32'd0);
    end

    // Busy blocking: requester 0 keeps valid high continuously
    clear_logs();
    p_auto[0] = 1'b1; p_vld[0] = 1'b1; p_a[0] = $urandom; p_b[0] = $urandom;
    repeat (3 * (LAT + 2) + 1) step();
    chk("busy_count", 32'(g_id.size()), 32'd4);
    for (int k = 1; k < 4; k++) begin
      chk("busy_period", 32'((k < g_cyc.size()) ? g_cyc[k] - g_cyc[k-1] : -1), 32'(LAT + 2));
    end
    p_auto[0] = 1'b0;
    repeat (2 * (LAT + 2)) step();

    // Overflow and underflow flags reach the right requester
    p_vld[1] = 1'b1; p_a[1] = 32'h7F000000; p_b[1] = 32'h7F000000;
    p_vld[2] = 1'b1; p_a[2] = 32'h00800000; p_b[2] = 32'h00800000;
    repeat (LAT + 5) step();
    chk("ovf_y", last_y[1], 32'h7F800000);
    chk("ovf_flag", 32'(last_ovf[1]), 32'd1);
    chk("ovf_noudf", 32'(last_udf[1]), 32'd0);
    chk("udf_y", last_y[2], 32'd0);
    chk("udf_flag", 32'(last_udf[2]), 32'd1);

    // Random traffic against the model
    rand_mode = 1'b1;
    repeat (400) step();
    rand_mode = 1'b0;
    repeat (3 * NREQ * (LAT + 2)) step();
    chk("drain_idle", 32'(idle), 32'd1);

    // Reset two cycles after an issue discards the operation
    clear_logs();
    p_vld[1] = 1'b1; p_a[1] = 32'h40400000; p_b[1] = 32'h40400000;
    step();
    step();
    do_reset(4'b1010);
    repeat (LAT + 4) step();
    chk("discard_no_pulse", 32'(pulse_id.size()), 32'd0);
    p_vld[3] = 1'b1; p_a[3] = 32'h40A00000; p_b[3] = 32'h40000000;
    repeat (LAT + 3) step();
    chk("post_rst_valid", 32'(res_valid), 32'b1000);
    chk("post_rst_y", res_y, 32'h41200000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
